voice_allocator: RTL

Polyphonic voice scheduler that sits between the song reader and the bank of note players. It accepts note requests over a valid/ready handshake and tracks which note players are busy. Each request goes to the lowest-index free player; when every player is busy, the oldest one is stolen. It replaces per-player new_note/busy wiring with one request port and a one-hot load bus. Per-player note and duration registers are held inside this block.

---
 rtl/voice_allocator.sv | 105 ++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: routes each accepted note request to the lowest free
// note player, or steals the oldest one when all are busy, and holds per-voice note data.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned NOTE_WIDTH = 6,
    parameter int unsigned DUR_WIDTH  = 6,
    parameter int unsigned STEAL      = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             play,
    input  logic                             note_valid,
    input  logic [NOTE_WIDTH-1:0]            note,
    input  logic [DUR_WIDTH-1:0]             duration,
    output logic                             note_ready,
    input  logic [NUM_VOICES-1:0]            note_done,
    output logic [NUM_VOICES-1:0]            load_new_note,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
    output logic [NUM_VOICES*DUR_WIDTH-1:0]  voice_duration,
    output logic [NUM_VOICES-1:0]            voice_busy,
    output logic                             stolen
);

    localparam int unsigned IDX_W  = 2;
    localparam int unsigned RANK_W = 2;
    localparam logic [RANK_W-1:0] RANK_OLDEST = RANK_W'(NUM_VOICES - 1);

    logic [RANK_W-1:0]     rank [NUM_VOICES];
    logic [NUM_VOICES-1:0] free_c;
    logic                  any_free_c;
    logic                  xfer_c;
    logic                  load_c;
    logic [IDX_W-1:0]      target_c;
    logic [NUM_VOICES-1:0] load_vec_c;
    logic [RANK_W-1:0]     target_rank_c;

    // A voice finishing this cycle is immediately reusable.
    assign free_c     = ~voice_busy | note_done;
    assign any_free_c = |free_c;
    assign note_ready = play & (any_free_c | (STEAL != 0));
    assign xfer_c     = note_valid & note_ready;
    assign load_c     = xfer_c & (duration != '0);

    // Target selection: lowest free voice, else the oldest by age rank.
    always_comb begin
        target_c = '0;
        if (any_free_c) begin
            for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
                if (free_c[i]) begin
                    target_c = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                if (rank[i] == RANK_OLDEST) begin
                    target_c = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        load_vec_c    = load_c ? (NUM_VOICES'(1) << target_c) : '0;
        target_rank_c = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (load_vec_c[i]) begin
                target_rank_c = rank[i];
            end
        end
    end

    // Voice state, age ranks and load/steal pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            voice_busy     <= '0;
            load_new_note  <= '0;
            stolen         <= 1'b0;
            voice_note     <= '0;
            voice_duration <= '0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                rank[i] <= RANK_W'(i);
            end
        end else begin
            load_new_note <= load_vec_c;
            stolen        <= load_c & ~any_free_c;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                if (load_vec_c[i]) begin
                    voice_busy[i]                                <= 1'b1;
                    voice_note[i*NOTE_WIDTH +: NOTE_WIDTH]       <= note;
                    voice_duration[i*DUR_WIDTH +: DUR_WIDTH]     <= duration;
                    rank[i]                                      <= '0;
                end else begin
                    if (note_done[i]) begin
                        voice_busy[i] <= 1'b0;
                    end
                    // Voices younger than the reloaded one age by one step.
                    if (load_c && (rank[i] < target_rank_c)) begin
                        rank[i] <= rank[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule
